// File: rtl/branch_predictor_pkg.sv
// Shared predictor types and helpers: counter encodings and PC index/tag slicing.
// Also intended for the I-cache and BTB blocks that use the same PC split.
package branch_predictor_pkg;

    function automatic int unsigned cnt_weak_t(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic int unsigned cnt_weak_nt(input int unsigned cnt_w);
        return cnt_weak_t(cnt_w) - 32'd1;
    endfunction

    // Word-aligned PCs: bits [1:0] never take part in index or tag
    function automatic logic [63:0] pc_index(
        input logic [63:0] pc,
        input int unsigned index_w
    );
        return (pc >> 2) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(
        input logic [63:0] pc,
        input int unsigned index_w
    );
        return pc >> (index_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down history counter with parallel load.
// Load has priority over inc, and inc has priority over dec.
module sat_counter #(
    parameter int unsigned W = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB: zero-latency lookup for IF, write-back from resolution,
// mispredict detection with recovery PC, and saturating branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_tgt_i,
    input  logic              flush_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] recover_pc_o,
    output logic [PERF_W-1:0] br_count_o,
    output logic [PERF_W-1:0] mis_count_o
);

    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;

    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];

    logic [INDEX_W-1:0] l_idx;
    logic [TAG_W-1:0]   l_tag;
    logic               l_hit;

    logic [INDEX_W-1:0] u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               u_hit;
    logic               upd_en;
    logic               perf_en;
    logic               alloc;

    logic [ENTRIES-1:0] hit_we;
    logic [ENTRIES-1:0] alloc_we;

    logic [PERF_W-1:0]  br_q;
    logic [PERF_W-1:0]  mis_q;

    logic               unused_pc_bits;

    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign l_idx = pc_i[INDEX_W+1:2];
    assign l_tag = pc_i[ADDR_W-1:INDEX_W+2];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign pred_taken_o  = l_hit && cnt_q[l_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? tgt_q[l_idx] : '0;

    assign mispredict_o = upd_valid_i &&
        ((upd_taken_i != upd_pred_taken_i) ||
         (upd_taken_i && (upd_target_i != upd_pred_tgt_i)));

    assign recover_pc_o = upd_taken_i ? upd_target_i
                                      : upd_pc_i + ADDR_W'(4);

    assign u_idx   = upd_pc_i[INDEX_W+1:2];
    assign u_tag   = upd_pc_i[ADDR_W-1:INDEX_W+2];
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // A same-cycle flush drops the table write but not the perf count
    assign upd_en  = upd_valid_i && start_i && !flush_i;
    assign perf_en = upd_valid_i && start_i;
    assign alloc   = upd_en && !u_hit && upd_taken_i;

    always_comb begin
        hit_we   = '0;
        alloc_we = '0;
        if (upd_en && u_hit) begin
            hit_we[u_idx] = 1'b1;
        end
        if (alloc) begin
            alloc_we[u_idx] = 1'b1;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        sat_counter #(
            .W       (CNT_W),
            .RST_VAL (WEAK_NT)
        ) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (hit_we[g] && upd_taken_i),
            .dec_i      (hit_we[g] && !upd_taken_i),
            .load_i     (alloc_we[g]),
            .load_val_i (WEAK_T),
            .cnt_o      (cnt_q[g])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (alloc) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target_i;
        end else if (upd_en && u_hit && upd_taken_i) begin
            tgt_q[u_idx] <= upd_target_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (perf_en) begin
            if (br_q != '1) begin
                br_q <= br_q + PERF_W'(1);
            end
            if (mispredict_o && (mis_q != '1)) begin
                mis_q <= mis_q + PERF_W'(1);
            end
        end
    end

    assign br_count_o  = br_q;
    assign mis_count_o = mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (16 entries, 2-bit counters):
// a vector table for steady sequences plus hand-written flush/start/reset cases.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_tgt_i;
    logic        flush_i;
    logic        mispredict_o;
    logic [31:0] recover_pc_o;
    logic [31:0] br_count_o;
    logic [31:0] mis_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor #(
        .ADDR_W  (32),
        .ENTRIES (16),
        .CNT_W   (2),
        .PERF_W  (32)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .pc_i             (pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_tgt_i   (upd_pred_tgt_i),
        .flush_i          (flush_i),
        .mispredict_o     (mispredict_o),
        .recover_pc_o     (recover_pc_o),
        .br_count_o       (br_count_o),
        .mis_count_o      (mis_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] etgt;
        logic        emis;
        logic [31:0] erec;
        int          ebr;
        int          emc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt);
        pc_i             = pc;
        upd_valid_i      = uv;
        upd_pc_i         = upc;
        upd_taken_i      = ut;
        upd_target_i     = utgt;
        upd_pred_taken_i = upt;
        upd_pred_tgt_i   = uptgt;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic add(input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic ept,
                       input logic [31:0] etgt, input logic emis,
                       input logic [31:0] erec, input int ebr,
                       input int emc);
        vec_t v;
        v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.ept = ept; v.etgt = etgt;
        v.emis = emis; v.erec = erec; v.ebr = ebr; v.emc = emc;
        tbl.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b1;
        flush_i = 1'b0;
        idle(32'h40);

        // pc    uv upc          ut utgt   upt uptgt  ept etgt   mis rec         br mc
        add(32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,   0, 0);
        add(32'h40, 1, 32'h40,  1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 0);
        add(32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h4,   1, 1);
        add(32'h40, 1, 32'h40,  0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  1, 1);
        add(32'h40, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  2, 2);
        add(32'h40, 1, 32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h44,  3, 2);
        add(32'h40, 1, 32'h40,  1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 4, 2);
        add(32'h40, 1, 32'h40,  1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 5, 3);
        add(32'h40, 1, 32'h40,  1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, 6, 4);
        add(32'h40, 1, 32'h40,  1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100, 7, 4);
        add(32'h40, 1, 32'h40,  0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  8, 4);
        add(32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h4,   9, 5);
        add(32'h40, 1, 32'h40,  1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 32'h200, 9, 5);
        add(32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h4,  10, 6);
        add(32'h40, 1, 32'h80,  1, 32'h300, 0, 32'h0,   1, 32'h200, 1, 32'h300,10, 6);
        add(32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h4,  11, 7);
        add(32'h80, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h4,  11, 7);
        add(32'h80, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 1, 32'h300, 0, 32'h0, 11, 7);
        add(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,   0, 32'h4,  12, 7);

        // Outputs held at reset values while reset is asserted
        #12;
        chk("rst_pred", {31'b0, pred_taken_o}, 32'h0);
        chk("rst_tgt", pred_target_o, 32'h0);
        chk("rst_br", br_count_o, 32'h0);
        chk("rst_mis", mis_count_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            string s;
            drive(tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ut,
                  tbl[i].utgt, tbl[i].upt, tbl[i].uptgt);
            #1;
            s = $sformatf("v%0d", i);
            chk({s, "_pred"}, {31'b0, pred_taken_o}, {31'b0, tbl[i].ept});
            chk({s, "_tgt"}, pred_target_o, tbl[i].etgt);
            chk({s, "_mis"}, {31'b0, mispredict_o}, {31'b0, tbl[i].emis});
            chk({s, "_rec"}, recover_pc_o, tbl[i].erec);
            chk({s, "_br"}, br_count_o, 32'(tbl[i].ebr));
            chk({s, "_mc"}, mis_count_o, 32'(tbl[i].emc));
            tick();
        end

        // Flush with a same-cycle allocating update on 0x44
        drive(32'h80, 1'b1, 32'h44, 1'b1, 32'h500, 1'b0, 32'h0);
        flush_i = 1'b1;
        #1;
        chk("fl_pre_pred", {31'b0, pred_taken_o}, 32'h1);
        tick();
        flush_i = 1'b0;
        idle(32'h80);
        #1;
        chk("fl_80_pred", {31'b0, pred_taken_o}, 32'h0);
        chk("fl_80_tgt", pred_target_o, 32'h0);
        pc_i = 32'h44;
        #1;
        chk("fl_44_pred", {31'b0, pred_taken_o}, 32'h0);
        chk("fl_br", br_count_o, 32'd13);
        chk("fl_mc", mis_count_o, 32'd8);

        // Allocate 0x40 again, then updates with start_i low
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h600);
            #1;
            chk($sformatf("st_mis%0d", i), {31'b0, mispredict_o}, 32'h1);
            tick();
        end
        drive(32'h40, 1'b1, 32'h44, 1'b1, 32'h700, 1'b0, 32'h0);
        tick();
        idle(32'h40);
        #1;
        chk("st_pred", {31'b0, pred_taken_o}, 32'h1);
        chk("st_tgt", pred_target_o, 32'h600);
        pc_i = 32'h44;
        #1;
        chk("st_44_pred", {31'b0, pred_taken_o}, 32'h0);
        chk("st_br", br_count_o, 32'd14);
        chk("st_mc", mis_count_o, 32'd9);

        // Asynchronous reset between edges
        start_i = 1'b1;
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h800, 1'b0, 32'h0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_pred", {31'b0, pred_taken_o}, 32'h0);
        chk("ar_tgt", pred_target_o, 32'h0);
        chk("ar_br", br_count_o, 32'h0);
        chk("ar_mc", mis_count_o, 32'h0);
        chk("ar_mis", {31'b0, mispredict_o}, 32'h1);
        chk("ar_rec", recover_pc_o, 32'h800);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(32'h40);
        #1;
        chk("ar_after_pred", {31'b0, pred_taken_o}, 32'h0);
        tick();
        chk("ar_after_br", br_count_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
